// File: rtl/nor_gate_selftest.sv
// nor_gate_selftest: built-in self-test sequencer for an N-input NOR gate.
// Walks every input vector, holds each for DWELL cycles, compares the gate
// output against the golden NOR on the last dwell cycle and reports results.
// Optional macro NOR_SELFTEST_STOP_ON_FAIL_EN: end the run at the first mismatch.
//
// Handshake: start is a level-sampled request with no ready signal. It is
// accepted on any rising edge where the engine is not busy (IDLE or DONE);
// while busy it is ignored entirely.
module nor_gate_selftest #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         gate_y,
  output logic [N-1:0] gate_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] fail_vec,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

`ifdef NOR_SELFTEST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t          state_q, state_d;
  logic [N-1:0]    vec_q, vec_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [N:0]      err_q, err_d;
  logic [N-1:0]    fail_q, fail_d;
  logic            pass_q, pass_d;

  logic            compare_now;
  logic            mismatch;
  logic            last_vec;

  // Compare strobe and golden-model check for the vector currently applied.
  always_comb begin
    compare_now = (state_q == S_RUN) && (dwell_q == DWELL_LAST);
    mismatch    = (gate_y != ~|vec_q);
    // The all-ones vector is detected directly rather than via counter wrap.
    last_vec    = &vec_q;
  end

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dwell_d = dwell_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = '0;
          dwell_d = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (compare_now) begin
          dwell_d = '0;
          if (mismatch) begin
            err_d = err_q + (N+1)'(1);
            // First failure of the run is the only one latched.
            if (err_q == '0) fail_d = vec_q;
          end
          if (last_vec || (STOP_ON_FAIL && mismatch)) begin
            state_d = S_DONE;
            vec_d   = '0;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + N'(1);
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      dwell_q <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  // Outputs come straight from registers; busy/done are state decodes.
  always_comb begin
    gate_in   = vec_q;
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    pass      = pass_q;
    err_count = err_q;
    fail_vec  = fail_q;
    dbg_state = state_q;
  end

endmodule
